// File: rtl/cpu_pkg.sv
// Shared definitions for the 11-bit teaching CPU: widths, instruction
// field positions and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 11;

  // Instruction word layout: [10] halt, [9] we, [8:7] rd, [6:4] op, [3:2] ra, [1:0] rb
  localparam int HALT_BIT = 10;
  localparam int WE_BIT   = 9;
  localparam int RD_MSB   = 8;
  localparam int RD_LSB   = 7;
  localparam int OP_MSB   = 6;
  localparam int OP_LSB   = 4;
  localparam int RA_MSB   = 3;
  localparam int RA_LSB   = 2;
  localparam int RB_MSB   = 1;
  localparam int RB_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer. Presents a registered PC to the
// combinational imem, latches the returned word into the instruction
// register and stops on the first halt-flagged instruction it captures.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  // State and datapath registers; reset forces everything to IDLE values without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state logic: everything holds by default and ir_valid is a one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    halted_d   = halted_q;
    retired_d  = retired_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // A stalled cycle captures nothing, so a halt word under stall is not seen yet.
        if (!stall) begin
          ir_d       = instr_in;
          ir_valid_d = 1'b1;
          retired_d  = retired_q + CNT_W'(1);
          if (instr_in[HALT_BIT]) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end

      HALT: begin
        // ir keeps the halt instruction; only start leaves this state.
        if (start) begin
          state_d   = RUN;
          pc_d      = '0;
          retired_d = '0;
          halted_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a behavioural combinational imem.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic [5:0]  pc;
  logic [10:0] instr_in;
  logic [10:0] ir;
  logic        ir_valid;
  logic        halted;
  logic [7:0]  retired;

  logic [10:0] mem [64];

  int n_vec;
  int n_err;

  fetch_unit #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .pc       (pc),
    .instr_in (instr_in),
    .ir       (ir),
    .ir_valid (ir_valid),
    .halted   (halted),
    .retired  (retired)
  );

  assign instr_in = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard program: 0x281 first, 0x586 (halt) at 0x1E, plain words between.
  task automatic load_std();
    for (int i = 0; i < 64; i++) mem[i] = 11'h000;
    mem[0] = 11'h281;
    for (int i = 1; i < 30; i++) mem[i] = 11'((i * 13 + 2) & 11'h3FF);
    mem[30] = 11'h586;
  endtask

  // Program with no halt bit anywhere.
  task automatic load_nohalt();
    for (int i = 0; i < 64; i++) mem[i] = 11'((i * 5 + 1) & 11'h3FF);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    load_std();
    #1;
    n_vec++; if (pc !== 6'h00) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 6'h00); end
    n_vec++; if (ir !== 11'h000) begin n_err++; $display("FAIL reset_ir: got %h want %h", ir, 11'h000); end
    n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_irv: got %b want 0", ir_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++; if (retired !== 8'd0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (pc !== 6'h00 || ir_valid !== 1'b0) begin n_err++; $display("FAIL idle_hold: got pc=%h irv=%b want pc=00 irv=0", pc, ir_valid); end
    end
  endtask

  task automatic test_run();
    pulse_start();
    n_vec++; if (pc !== 6'h00 || ir_valid !== 1'b0) begin n_err++; $display("FAIL run_first: got pc=%h irv=%b want pc=00 irv=0", pc, ir_valid); end
    for (int k = 0; k < 31; k++) begin
      tick();
      n_vec++;
      if (ir_valid !== 1'b1 || ir !== mem[k] || retired !== 8'(k + 1) ||
          pc !== ((k < 30) ? 6'(k + 1) : 6'h1E) || halted !== (k == 30)) begin
        n_err++;
        $display("FAIL run_step%0d: got pc=%h ir=%h irv=%b ret=%0d h=%b want pc=%h ir=%h irv=1 ret=%0d h=%b",
                 k, pc, ir, ir_valid, retired, halted, (k < 30) ? 6'(k + 1) : 6'h1E, mem[k], k + 1, k == 30);
      end
    end
    tick();
    n_vec++;
    if (halted !== 1'b1 || pc !== 6'h1E || ir !== 11'h586 || retired !== 8'd31 || ir_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run_halt: got h=%b pc=%h ir=%h ret=%0d irv=%b want h=1 pc=1e ir=586 ret=31 irv=0",
               halted, pc, ir, retired, ir_valid);
    end
  endtask

  task automatic test_restart();
    stall = 1'b1;  // ignored in HALT
    tick();
    stall = 1'b0;
    n_vec++; if (halted !== 1'b1 || pc !== 6'h1E) begin n_err++; $display("FAIL halt_stall_ign: got h=%b pc=%h want h=1 pc=1e", halted, pc); end
    pulse_start();
    n_vec++;
    if (pc !== 6'h00 || retired !== 8'd0 || halted !== 1'b0 || ir_valid !== 1'b0 || ir !== 11'h586) begin
      n_err++;
      $display("FAIL restart: got pc=%h ret=%0d h=%b irv=%b ir=%h want pc=00 ret=0 h=0 irv=0 ir=586",
               pc, retired, halted, ir_valid, ir);
    end
    for (int k = 0; k < 31; k++) begin
      tick();
      n_vec++;
      if (ir_valid !== 1'b1 || ir !== mem[k] || retired !== 8'(k + 1) || halted !== (k == 30)) begin
        n_err++;
        $display("FAIL rerun_step%0d: got ir=%h irv=%b ret=%0d h=%b want ir=%h irv=1 ret=%0d h=%b",
                 k, ir, ir_valid, retired, halted, mem[k], k + 1, k == 30);
      end
    end
    n_vec++; if (pc !== 6'h1E) begin n_err++; $display("FAIL rerun_pc: got %h want 1e", pc); end
  endtask

  task automatic test_stall();
    pulse_start();
    for (int k = 0; k < 7; k++) tick();
    n_vec++; if (pc !== 6'h07 || retired !== 8'd7) begin n_err++; $display("FAIL pre_stall: got pc=%h ret=%0d want pc=07 ret=7", pc, retired); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (pc !== 6'h07 || ir_valid !== 1'b0 || retired !== 8'd7 || ir !== mem[6]) begin
        n_err++;
        $display("FAIL stall_cyc%0d: got pc=%h irv=%b ret=%0d ir=%h want pc=07 irv=0 ret=7 ir=%h",
                 i, pc, ir_valid, retired, ir, mem[6]);
      end
    end
    stall = 1'b0;
    tick();
    n_vec++;
    if (ir !== mem[7] || ir_valid !== 1'b1 || retired !== 8'd8 || pc !== 6'h08) begin
      n_err++;
      $display("FAIL stall_resume: got ir=%h irv=%b ret=%0d pc=%h want ir=%h irv=1 ret=8 pc=08",
               ir, ir_valid, retired, pc, mem[7]);
    end
    for (int k = 8; k < 31; k++) tick();
    n_vec++; if (halted !== 1'b1 || retired !== 8'd31 || pc !== 6'h1E) begin n_err++; $display("FAIL stall_final: got h=%b ret=%0d pc=%h want h=1 ret=31 pc=1e", halted, retired, pc); end
  endtask

  task automatic test_stall_at_halt();
    pulse_start();
    for (int k = 0; k < 30; k++) tick();
    n_vec++; if (pc !== 6'h1E || halted !== 1'b0) begin n_err++; $display("FAIL pre_halt: got pc=%h h=%b want pc=1e h=0", pc, halted); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (halted !== 1'b0 || pc !== 6'h1E || ir_valid !== 1'b0 || retired !== 8'd30) begin
        n_err++;
        $display("FAIL halt_stalled%0d: got h=%b pc=%h irv=%b ret=%0d want h=0 pc=1e irv=0 ret=30",
                 i, halted, pc, ir_valid, retired);
      end
    end
    stall = 1'b0;
    tick();
    n_vec++;
    if (halted !== 1'b1 || ir !== 11'h586 || ir_valid !== 1'b1 || retired !== 8'd31 || pc !== 6'h1E) begin
      n_err++;
      $display("FAIL halt_after_stall: got h=%b ir=%h irv=%b ret=%0d pc=%h want h=1 ir=586 irv=1 ret=31 pc=1e",
               halted, ir, ir_valid, retired, pc);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    load_nohalt();
    tick();
    pulse_start();
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 63 || k == 64 || k == 65) begin
        n_vec++; if (pc !== 6'(k % 64)) begin n_err++; $display("FAIL wrap_pc%0d: got %h want %h", k, pc, 6'(k % 64)); end
      end
      if (k == 255) begin
        n_vec++; if (retired !== 8'd255) begin n_err++; $display("FAIL wrap_ret255: got %0d want 255", retired); end
      end
      if (halted !== 1'b0) begin
        n_vec++; n_err++; $display("FAIL wrap_halted%0d: got %b want 0", k, halted);
      end
    end
    n_vec++;
    if (retired !== 8'd0 || ir_valid !== 1'b1 || halted !== 1'b0 || ir !== mem[63]) begin
      n_err++;
      $display("FAIL wrap_ret0: got ret=%0d irv=%b h=%b ir=%h want ret=0 irv=1 h=0 ir=%h",
               retired, ir_valid, halted, ir, mem[63]);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    load_std();
    tick();
    pulse_start();
    for (int k = 0; k < 16; k++) tick();
    n_vec++; if (pc !== 6'h10 || ir_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst: got pc=%h irv=%b want pc=10 irv=1", pc, ir_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (pc !== 6'h00 || ir !== 11'h000 || ir_valid !== 1'b0 || retired !== 8'd0 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got pc=%h ir=%h irv=%b ret=%0d h=%b want all zero", pc, ir, ir_valid, retired, halted);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (pc !== 6'h00 || ir_valid !== 1'b0 || retired !== 8'd0) begin
        n_err++;
        $display("FAIL post_rst_idle%0d: got pc=%h irv=%b ret=%0d want pc=00 irv=0 ret=0", i, pc, ir_valid, retired);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_run();
    test_restart();
    test_stall();
    test_stall_at_halt();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
